// File: rtl/mul_div_unit.sv
// Iterative unsigned 16-bit multiply/divide unit: 16 shift-add or restoring-divide
// iterations, then a one-cycle register-file write-back request.
module mul_div_unit #(
  parameter int WIDTH = 16,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    dst_reg,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             wb_we,
  output logic [AW-1:0]    wb_reg,
  output logic [WIDTH-1:0] wb_data,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: an op is accepted on any rising edge where start=1 and the unit
  // is IDLE (busy=0); done/wb_we pulse for exactly one cycle with the result.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  state_t             state;
  logic [3:0]         cnt;
  logic [1:0]         op_q;
  logic [AW-1:0]      dst_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;

  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic               q_bit;
  logic               b_zero;
  logic [WIDTH-1:0]   result;

  always_comb begin
    prod_nxt = prod_q;
    if (b_q[cnt])
      prod_nxt = prod_q + ({{WIDTH{1'b0}}, a_q} << cnt);
    // Dividend bits enter MSB-first: iteration cnt consumes bit 15-cnt.
    rem_sh  = {rem_q[WIDTH-1:0], a_q[~cnt]};
    q_bit   = (rem_sh >= {1'b0, b_q});
    rem_nxt = q_bit ? (rem_sh - {1'b0, b_q}) : rem_sh;
    quo_nxt = {quo_q[WIDTH-2:0], q_bit};
    b_zero  = (b_q == '0);
    result  = '0;
    case (op_q)
      OP_MUL:  result = prod_nxt[WIDTH-1:0];
      OP_MULH: result = prod_nxt[2*WIDTH-1:WIDTH];
      OP_DIV:  result = b_zero ? {WIDTH{1'b1}} : quo_nxt;
      default: result = b_zero ? a_q : rem_nxt[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      dst_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wb_we       <= 1'b0;
      wb_reg      <= '0;
      wb_data     <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            dst_q  <= dst_reg;
            a_q    <= src_a;
            b_q    <= src_b;
            prod_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          prod_q <= prod_nxt;
          rem_q  <= rem_nxt;
          quo_q  <= quo_nxt;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            done        <= 1'b1;
            wb_we       <= 1'b1;
            wb_reg      <= dst_q;
            wb_data     <= result;
            div_by_zero <= op_q[1] && b_zero;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          done        <= 1'b0;
          wb_we       <= 1'b0;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  dst_reg;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic        busy;
  logic        done;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [15:0] wb_data;
  logic        div_by_zero;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  mul_div_unit #(.WIDTH(16), .AW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dst_reg(dst_reg),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .wb_we(wb_we),
    .wb_reg(wb_reg), .wb_data(wb_data), .div_by_zero(div_by_zero),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (o)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (b == 16'h0) ? 16'hFFFF : a / b;
      default: return (b == 16'h0) ? a : a % b;
    endcase
  endfunction

  // Drive one start pulse so it is sampled at the next edge (E0), then scramble inputs.
  task automatic drive_start(input logic [1:0] o, input logic [4:0] d,
                             input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op = o; dst_reg = d; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); dst_reg = 5'($urandom);
    src_a = 16'($urandom); src_b = 16'($urandom);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [4:0] d, input logic [15:0] a,
                        input logic [15:0] b, input bit junk);
    int lat;
    logic [15:0] exp_data;
    logic exp_dbz;
    exp_q.push_back(model(o, a, b));
    exp_dbz = o[1] && (b == 16'h0);
    drive_start(o, d, a, b);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) check("busy_after_issue", 32'(busy), 32'd1);
      if (junk && i == 5) begin
        start = 1'b1; op = 2'($urandom); src_a = 16'($urandom); src_b = 16'($urandom);
      end
      if (wb_we) begin
        lat = i;
        break;
      end
    end
    exp_data = exp_q.pop_front();
    check("latency", 32'(lat), 32'd17);
    check("done", 32'(done), 32'd1);
    check("wb_reg", 32'(wb_reg), 32'(d));
    check("wb_data", 32'(wb_data), 32'(exp_data));
    check("div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
    if (junk) begin
      start = 1'b1; op = 2'($urandom); src_a = 16'($urandom); src_b = 16'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    check("wb_we_pulse", 32'(wb_we), 32'd0);
    check("done_pulse", 32'(done), 32'd0);
    check("dbz_pulse", 32'(div_by_zero), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
    check("wb_data_hold", 32'(wb_data), 32'(exp_data));
    if (junk) begin
      @(negedge clk);
      check("done_start_ignored", 32'(busy), 32'd0);
      check("no_extra_wb", 32'(wb_we), 32'd0);
    end
  endtask

  initial begin
    int seen;
    logic [15:0] rb;
    rst = 1'b1; start = 1'b0; op = '0; dst_reg = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_wb_reg", 32'(wb_reg), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    run_op(2'b00, 5'd7, 16'd3, 16'd5, 1'b0);
    run_op(2'b00, 5'd1, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op(2'b01, 5'd2, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op(2'b10, 5'd3, 16'd100, 16'd7, 1'b0);
    run_op(2'b11, 5'd4, 16'd100, 16'd7, 1'b0);
    run_op(2'b10, 5'd0, 16'h8000, 16'd1, 1'b0);
    run_op(2'b11, 5'd31, 16'd5, 16'd9, 1'b0);
    run_op(2'b10, 5'd5, 16'd1234, 16'd0, 1'b0);
    run_op(2'b11, 5'd6, 16'd1234, 16'd0, 1'b0);
    run_op(2'b00, 5'd12, 16'd345, 16'd678, 1'b1);

    for (int k = 0; k < 24; k++) begin
      rb = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      run_op(2'($urandom_range(0, 3)), 5'($urandom), 16'($urandom), rb, 1'b0);
    end

    // Reset while an op is in flight: discarded, no write-back.
    run_op(2'b00, 5'd3, 16'd300, 16'd3, 1'b0);
    drive_start(2'b00, 5'd9, 16'd1000, 16'd1000);
    repeat (8) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    check("midrst_wb_we", 32'(wb_we), 32'd0);
    check("midrst_wb_reg", 32'(wb_reg), 32'd0);
    check("midrst_wb_data", 32'(wb_data), 32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (wb_we || busy) seen++;
    end
    check("midrst_no_wb", 32'(seen), 32'd0);
    run_op(2'b01, 5'd31, 16'hABCD, 16'h1234, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
